video_stream_src: RTL and testbench



---
 rtl/video_stream_pkg.sv | 31 +++
 rtl/video_stream_src_if.sv | 20 ++
 rtl/video_stream_src_timing.sv | 62 ++++++
 rtl/video_stream_src.sv | 149 ++++++++++++++
 tb/tb_video_stream_src.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_stream_pkg.sv
// video_stream_pkg
//   Shared types and default timing for the video stream source and the
//   mean-filter testbenches that consume its stream.
//   - vsrc_state_e : source FSM states (IDLE / RUN / DRAIN)
//   - vsrc_mode_e  : test pattern select (CONST / HRAMP / VRAMP / XOR)
//   - DEF_*        : default 640x480 timing inside a 1440x525 raster
package video_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vsrc_state_e;

    typedef enum logic [1:0] {
        PAT_CONST = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_XOR   = 2'd3
    } vsrc_mode_e;

    localparam int DEF_IW      = 640;
    localparam int DEF_IH      = 480;
    localparam int DEF_H_TOTAL = 1440;
    localparam int DEF_V_TOTAL = 525;
    localparam int DEF_H_BACK  = 200;
    localparam int DEF_V_BACK  = 20;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/video_stream_src_if.sv
// video_stream_src_if
//   Pixel stream bundle between the source and the filter chain.
//   Handshake: push-only stream with no backpressure. dout_hsync is the
//   per-pixel valid; there is no ready, so the consumer must take a pixel
//   on every clock that dout_hsync is high. dout_vsync frames whole active
//   lines (it is high across porches inside those lines too).
//   Ports (modport master = source side, slave = consumer side):
//     dout_vsync  1   frame-valid, high across whole active lines
//     dout_hsync  1   line-valid, high over active pixels
//     dout        DW  pixel, 0 when dout_hsync is low
interface video_stream_src_if #(
    parameter int DW = 8
);
    logic          dout_vsync;
    logic          dout_hsync;
    logic [DW-1:0] dout;

    modport master (output dout_vsync, output dout_hsync, output dout);
    modport slave  (input  dout_vsync, input  dout_hsync, input  dout);
endinterface

// File: rtl/video_stream_src_timing.sv
// vsrc_timing
//   Raster counter pair for the video stream source. h_cnt runs
//   0..H_TOTAL-1, v_cnt runs 0..V_TOTAL-1 and steps when h_cnt wraps.
//   Both counters are held at 0 whenever run is low.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     run                 advance enable (source FSM not idle)
//     h_cnt, v_cnt        raster position
//     frame_end           run and position is the last clock of the frame
//     vs_region           v_cnt inside the active lines
//     hs_region           vs_region and h_cnt inside the active pixels
module vsrc_timing #(
    parameter int H_TOTAL = 1440,
    parameter int H_BACK  = 200,
    parameter int IW      = 640,
    parameter int V_TOTAL = 525,
    parameter int V_BACK  = 20,
    parameter int IH      = 480,
    parameter int HW      = $clog2(H_TOTAL + 1),
    parameter int VW      = $clog2(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          frame_end,
    output logic          vs_region,
    output logic          hs_region
);
    // Widths carry one spare value so the exclusive end bounds
    // (H_BACK+IW may equal H_TOTAL) fit without wrapping.
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT0 = HW'(H_BACK);
    localparam logic [HW-1:0] H_ACT1 = HW'(H_BACK + IW);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT0 = VW'(V_BACK);
    localparam logic [VW-1:0] V_ACT1 = VW'(V_BACK + IH);

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign frame_end = run && h_last && v_last;
    assign vs_region = (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
    assign hs_region = vs_region && (h_cnt >= H_ACT0) && (h_cnt < H_ACT1);

endmodule

// File: rtl/video_stream_src.sv
// video_stream_src
//   Test-pattern video source feeding the mean-filter chain. A raster
//   counter pair (vsrc_timing) is decoded into registered vsync/hsync/pixel
//   outputs, so every output shows the counter state one clock later.
//   A frame, once started, always runs to its last clock; only rst aborts.
//   Optional build macro: VSRC_FRAME_CNT_EN adds the frame_cnt output and
//   turns pattern mode 1 into a ramp that scrolls by one per frame.
//   Ports:
//     clk, rst     pixel clock, synchronous active-high reset
//     en           run request (level)
//     mode         pattern select, taken at frame start only
//     vs           stream bundle (master): dout_vsync, dout_hsync, dout
//     frame_done   one-clock pulse on the last clock of each frame
//     busy         FSM not IDLE
//     fsm_state    current FSM state, for observation
//     frame_cnt    (VSRC_FRAME_CNT_EN only) completed-frame count, wraps
module video_stream_src
    import video_stream_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            IW        = DEF_IW,
    parameter int            IH        = DEF_IH,
    parameter int            H_TOTAL   = DEF_H_TOTAL,
    parameter int            H_BACK    = DEF_H_BACK,
    parameter int            V_TOTAL   = DEF_V_TOTAL,
    parameter int            V_BACK    = DEF_V_BACK,
    parameter logic [DW-1:0] CONST_VAL = 8'h80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    video_stream_src_if.master vs,
    output logic               frame_done,
    output logic               busy,
    output vsrc_state_e        fsm_state
`ifdef VSRC_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    vsrc_state_e   state_q;
    vsrc_state_e   state_d;
    vsrc_mode_e    mode_q;
    vsrc_mode_e    mode_eff;
    logic          run;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_end;
    logic          vs_region;
    logic          hs_region;
    logic          frame_start;
    logic [DW-1:0] x_px;
    logic [DW-1:0] y_px;
    logic [DW-1:0] pix;

    assign run       = (state_q != ST_IDLE);
    assign busy      = run;
    assign fsm_state = state_q;

    vsrc_timing #(
        .H_TOTAL (H_TOTAL),
        .H_BACK  (H_BACK),
        .IW      (IW),
        .V_TOTAL (V_TOTAL),
        .V_BACK  (V_BACK),
        .IH      (IH),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .frame_end (frame_end),
        .vs_region (vs_region),
        .hs_region (hs_region)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Dropping en on the very last clock of a frame has nothing left to
    // drain, so RUN goes straight to IDLE there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (frame_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ pattern
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);

    // At (0,0) the live mode is decoded directly so the frame-start pixel
    // already follows the newly latched mode.
    assign mode_eff = frame_start ? vsrc_mode_e'(mode) : mode_q;

    // x/y are only used inside the active region, where the counter
    // difference is non-negative and fits the counter width.
    always_comb begin
        x_px = DW'(h_cnt - HW'(H_BACK));
        y_px = DW'(v_cnt - VW'(V_BACK));
`ifdef VSRC_FRAME_CNT_EN
        if (mode_eff == PAT_HRAMP) x_px = x_px + DW'(frame_cnt);
`endif
        case (mode_eff)
            PAT_CONST: pix = CONST_VAL;
            PAT_HRAMP: pix = x_px;
            PAT_VRAMP: pix = y_px;
            default:   pix = x_px ^ y_px;
        endcase
    end

    // ------------------------------------------------------ output decode
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= PAT_CONST;
            vs.dout_vsync <= 1'b0;
            vs.dout_hsync <= 1'b0;
            vs.dout       <= '0;
            frame_done    <= 1'b0;
        end else begin
            if (frame_start) mode_q <= vsrc_mode_e'(mode);
            vs.dout_vsync <= run && vs_region;
            vs.dout_hsync <= run && hs_region;
            vs.dout       <= (run && hs_region) ? pix : '0;
            frame_done    <= frame_end;
        end
    end

`ifdef VSRC_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)             frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_video_stream_src.sv
`timescale 1ns/1ps
module tb_video_stream_src;
  import video_stream_pkg::*;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 3;
  localparam int HT = 8;
  localparam int HB = 2;
  localparam int VT = 6;
  localparam int VB = 1;
  localparam int FRAME = HT * VT;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic frame_done;
  logic busy;
  vsrc_state_e fsm_state;
`ifdef VSRC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  video_stream_src_if #(.DW(DW)) vs ();

  video_stream_src #(
    .DW(DW), .IW(IW), .IH(IH), .H_TOTAL(HT), .H_BACK(HB),
    .V_TOTAL(VT), .V_BACK(VB), .CONST_VAL(8'h80)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .vs(vs),
    .frame_done(frame_done),
    .busy(busy),
    .fsm_state(fsm_state)
`ifdef VSRC_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  // ---------------------------------------------------- scoreboard state
  int total = 0;
  int bad = 0;

  // Reference model: frame position as one integer (-1 = idle).
  int pos = -1;
  bit drain = 0;
  int mode_lat = 0;
  logic exp_vs = 0, exp_hs = 0, exp_fd = 0, exp_busy = 0;
  logic [DW-1:0] exp_dout = '0;
  vsrc_state_e exp_state = ST_IDLE;
`ifdef VSRC_FRAME_CNT_EN
  int fcnt = 0;
`endif

  // Directed observation helpers
  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] exp_q[$];
  int cyc = 0;
  int vs_first = -1;
  int vs_cnt = 0;
  int fd_cnt = 0;
  int fd_last = -1;
  int fd_gap = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int m, input int x, input int y);
    case (m)
      0: return 8'h80;
      1: return DW'(x);
      2: return DW'(y);
      default: return DW'(x ^ y);
    endcase
  endfunction

  // Advance the model by one rising edge, using the inputs present there.
  task automatic model_edge();
    int v, h, xe;
    logic old_fd;
    old_fd = exp_fd;
    if (rst) begin
      pos = -1; drain = 0; mode_lat = 0;
      exp_vs = 0; exp_hs = 0; exp_dout = '0; exp_fd = 0;
`ifdef VSRC_FRAME_CNT_EN
      fcnt = 0;
`endif
    end else begin
      if (pos >= 0) begin
        v = pos / HT;
        h = pos % HT;
        if (pos == 0) mode_lat = mode;
        xe = h - HB;
`ifdef VSRC_FRAME_CNT_EN
        if (mode_lat == 1) xe = xe + fcnt;
`endif
        exp_vs = (v >= VB) && (v < VB + IH);
        exp_hs = exp_vs && (h >= HB) && (h < HB + IW);
        exp_dout = exp_hs ? pattern(mode_lat, xe, v - VB) : '0;
        exp_fd = (pos == FRAME - 1);
        if (!en) drain = 1;
        if (pos == FRAME - 1) begin
          if (drain) begin pos = -1; drain = 0; end
          else pos = 0;
        end else begin
          pos++;
        end
      end else begin
        exp_vs = 0; exp_hs = 0; exp_dout = '0; exp_fd = 0;
        if (en) pos = 0;
      end
`ifdef VSRC_FRAME_CNT_EN
      if (old_fd) fcnt = (fcnt + 1) & 16'hFFFF;
`endif
    end
    exp_busy = (pos >= 0);
    exp_state = (pos < 0) ? ST_IDLE : (drain ? ST_DRAIN : ST_RUN);
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    chk("vsync", vs.dout_vsync, exp_vs);
    chk("hsync", vs.dout_hsync, exp_hs);
    chk("dout", vs.dout, exp_dout);
    chk("frame_done", frame_done, exp_fd);
    chk("busy", busy, exp_busy);
    chk("state", fsm_state, exp_state);
`ifdef VSRC_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, fcnt);
`endif
    if (vs.dout_hsync) cap_q.push_back(vs.dout);
    if (vs.dout_vsync) begin
      vs_cnt++;
      if (vs_first < 0) vs_first = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_gap = cyc - fd_last;
      fd_last = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    cap_q.delete();
    exp_q.delete();
    cyc = 0; vs_first = -1; vs_cnt = 0; fd_cnt = 0; fd_last = -1; fd_gap = -1;
  endtask

  // Push one active line of four expected pixels.
  task automatic exp_line(input int a, input int b, input int c, input int d);
    exp_q.push_back(DW'(a)); exp_q.push_back(DW'(b));
    exp_q.push_back(DW'(c)); exp_q.push_back(DW'(d));
  endtask

  task automatic cmp_caps(input string tag);
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_vsync"}, vs.dout_vsync, 1'b0);
    chk({tag, "_hsync"}, vs.dout_hsync, 1'b0);
    chk({tag, "_dout"}, vs.dout, '0);
    chk({tag, "_fd"}, frame_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------------------------------------------- directed + random
  initial begin
    // Reset state
    rst = 1; en = 0; mode = 0;
    steps(3);
    chk_quiet("reset");
    rst = 0;
    step();

    // Mode 1, en held: timing of first frame
    clear_obs();
    mode = 1; en = 1;
    steps(49);
    chk("m1_vs_start", vs_first, 10);
    chk("m1_vs_len", vs_cnt, 24);
    chk("m1_fd_at", fd_last, 49);
    chk("m1_fd_cnt", fd_cnt, 1);
    exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3);
    cmp_caps("m1");

    // Mode 3 on the next back-to-back frame
    mode = 3;
    steps(48);
    chk("m3_fd_gap", fd_gap, 48);
    chk("m3_fd_cnt", fd_cnt, 2);
    exp_line(0, 1, 2, 3); exp_line(1, 0, 3, 2); exp_line(2, 3, 0, 1);
    cmp_caps("m3");

    // Mode 1 -> 2 mid-frame: change lands on the next frame
    mode = 1;
    steps(20);
    mode = 2;
    steps(28);
    exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3);
    cmp_caps("sw_cur");
    steps(48);
    exp_line(0, 0, 0, 0); exp_line(1, 1, 1, 1); exp_line(2, 2, 2, 2);
    cmp_caps("sw_next");

    // en dropped at the 10th clock: frame completes, then idle
    steps(10);
    en = 0;
    clear_obs();
    steps(38);
    chk("drain_fd_at", fd_last, 38);
    steps(5);
    chk_quiet("drain_idle");
    chk("drain_fd_cnt", fd_cnt, 1);

    // rst in the middle of an active line
    mode = 1; en = 1;
    steps(13);
    chk("pre_rst_hsync", vs.dout_hsync, 1'b1);
    rst = 1;
    step();
    chk_quiet("mid_rst");
    rst = 0;
    clear_obs();
    steps(49);
    chk("rst_vs_start", vs_first, 10);
    chk("rst_vs_len", vs_cnt, 24);
    chk("rst_fd_at", fd_last, 49);
    exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3); exp_line(0, 1, 2, 3);
    cmp_caps("rst_frame");

    // Random en / mode / rst against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; en = 0;
    steps(2 * FRAME + 5);
    chk_quiet("rand_end");

`ifdef VSRC_FRAME_CNT_EN
    // Scrolling ramp across three frames
    rst = 1;
    step();
    rst = 0; mode = 1; en = 1;
    step();
    for (int f = 0; f < 3; f++) begin
      clear_obs();
      steps(24);
      chk($sformatf("fcnt_f%0d", f), frame_cnt, f);
      steps(24);
    end
    exp_line(2, 3, 4, 5); exp_line(2, 3, 4, 5); exp_line(2, 3, 4, 5);
    cmp_caps("scroll_f2");
    en = 0;
    steps(FRAME + 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
